// File: rtl/axis_route_merge_if.sv
// Bundle of every stream signal of axis_route_merge: the split input (s_*), split
// outputs (dm_*), merge inputs (mm_*) and merged output (m_*), with lanes packed
// as [i*W +: W]. The switch uses the slave modport, its environment the master one.
interface axis_route_merge_if #(
  parameter int unsigned NUM   = 3,
  parameter int unsigned DSIZE = 32,
  parameter int unsigned USIZE = 1
) ();
  localparam int unsigned KSIZE = DSIZE / 8;
  localparam int unsigned AW    = (NUM > 1) ? $clog2(NUM) : 1;

  logic [AW-1:0]          addr;
  logic [DSIZE-1:0]       s_tdata;
  logic [KSIZE-1:0]       s_tkeep;
  logic [USIZE-1:0]       s_tuser;
  logic                   s_tvalid;
  logic                   s_tlast;
  logic                   s_tready;

  logic [NUM*DSIZE-1:0]   dm_tdata;
  logic [NUM*KSIZE-1:0]   dm_tkeep;
  logic [NUM*USIZE-1:0]   dm_tuser;
  logic [NUM-1:0]         dm_tvalid;
  logic [NUM-1:0]         dm_tlast;
  logic [NUM-1:0]         dm_tready;

  logic [NUM*DSIZE-1:0]   mm_tdata;
  logic [NUM*KSIZE-1:0]   mm_tkeep;
  logic [NUM*USIZE-1:0]   mm_tuser;
  logic [NUM-1:0]         mm_tvalid;
  logic [NUM-1:0]         mm_tlast;
  logic [NUM-1:0]         mm_tready;

  logic [DSIZE-1:0]       m_tdata;
  logic [KSIZE-1:0]       m_tkeep;
  logic [USIZE-1:0]       m_tuser;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   m_tready;

  modport slave (
    input  addr, s_tdata, s_tkeep, s_tuser, s_tvalid, s_tlast,
    output s_tready,
    output dm_tdata, dm_tkeep, dm_tuser, dm_tvalid, dm_tlast,
    input  dm_tready,
    input  mm_tdata, mm_tkeep, mm_tuser, mm_tvalid, mm_tlast,
    output mm_tready,
    output m_tdata, m_tkeep, m_tuser, m_tvalid, m_tlast,
    input  m_tready
  );

  modport master (
    output addr, s_tdata, s_tkeep, s_tuser, s_tvalid, s_tlast,
    input  s_tready,
    input  dm_tdata, dm_tkeep, dm_tuser, dm_tvalid, dm_tlast,
    output dm_tready,
    output mm_tdata, mm_tkeep, mm_tuser, mm_tvalid, mm_tlast,
    input  mm_tready,
    input  m_tdata, m_tkeep, m_tuser, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/axis_route_merge.sv
// Packet-atomic AXI-Stream split (1 -> NUM by addr) and merge (NUM -> 1 round-robin).
// Optional macro AXIS_ROUTE_MERGE_OUT_REG_EN puts a 2-entry skid buffer on the merged
// output (one extra cycle of latency, registered m_*); without it m_* is driven
// combinationally from the granted lane.
module axis_route_merge #(
  parameter int unsigned NUM   = 3,
  parameter int unsigned DSIZE = 32,
  parameter int unsigned USIZE = 1
) (
  input  logic               aclk,
  input  logic               areset,
  axis_route_merge_if.slave  bus
);
  localparam int unsigned KSIZE = DSIZE / 8;
  localparam int unsigned AW    = (NUM > 1) ? $clog2(NUM) : 1;

  // ---------------- split half ----------------
  logic          locked_q;
  logic [AW-1:0] sel_q;
  logic [AW-1:0] sel_c;
  logic          drop_c;

  // Payload fans out to every lane; only the selected lane sees tvalid.
  assign bus.dm_tdata = {NUM{bus.s_tdata}};
  assign bus.dm_tkeep = {NUM{bus.s_tkeep}};
  assign bus.dm_tuser = {NUM{bus.s_tuser}};
  assign bus.dm_tlast = {NUM{bus.s_tlast}};

  // Lane select: live addr between packets, locked value inside a packet; out-of-range drops.
  always_comb begin
    sel_c         = locked_q ? sel_q : bus.addr;
    drop_c        = ({1'b0, sel_c} >= (AW+1)'(NUM));
    bus.dm_tvalid = '0;
    bus.s_tready  = 1'b0;
    if (areset) begin
      bus.s_tready = bus.dm_tready[0];
    end else if (drop_c) begin
      bus.s_tready = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM; i++) begin
        if (sel_c == AW'(i)) begin
          bus.dm_tvalid[i] = bus.s_tvalid;
          bus.s_tready     = bus.dm_tready[i];
        end
      end
    end
  end

  // Lock on the first accepted beat, release on the accepted tlast beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      locked_q <= 1'b0;
      sel_q    <= '0;
    end else if (bus.s_tvalid && bus.s_tready) begin
      if (bus.s_tlast) begin
        locked_q <= 1'b0;
      end else if (!locked_q) begin
        locked_q <= 1'b1;
        sel_q    <= bus.addr;
      end
    end
  end

  // ---------------- merge half ----------------
  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q;
  logic [AW-1:0]    grant_q;
  logic             scan_hit;
  logic [AW-1:0]    scan_lane;
  int unsigned      scan_idx;
  logic [DSIZE-1:0] cur_tdata;
  logic [KSIZE-1:0] cur_tkeep;
  logic [USIZE-1:0] cur_tuser;
  logic             cur_tvalid;
  logic             cur_tlast;
  logic             take_c;
  logic             xfer_c;

  // Round-robin scan starting just after the last grant, so the served lane comes last.
  always_comb begin
    scan_hit  = 1'b0;
    scan_lane = grant_q;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NUM; k++) begin
      scan_idx = (32'(grant_q) + k) % NUM;
      for (int unsigned j = 0; j < NUM; j++) begin
        if (!scan_hit && (scan_idx == j) && bus.mm_tvalid[j]) begin
          scan_hit  = 1'b1;
          scan_lane = AW'(j);
        end
      end
    end
  end

  // Granted-lane mux and per-lane ready; nothing is ready while idle.
  always_comb begin
    cur_tdata     = '0;
    cur_tkeep     = '0;
    cur_tuser     = '0;
    cur_tvalid    = 1'b0;
    cur_tlast     = 1'b0;
    bus.mm_tready = '0;
    for (int unsigned j = 0; j < NUM; j++) begin
      if (grant_q == AW'(j)) begin
        cur_tdata        = bus.mm_tdata[j*DSIZE +: DSIZE];
        cur_tkeep        = bus.mm_tkeep[j*KSIZE +: KSIZE];
        cur_tuser        = bus.mm_tuser[j*USIZE +: USIZE];
        cur_tvalid       = bus.mm_tvalid[j] && (state_q == LOCK);
        cur_tlast        = bus.mm_tlast[j];
        bus.mm_tready[j] = (state_q == LOCK) && take_c;
      end
    end
  end

  assign xfer_c = cur_tvalid && take_c;

  // Arbiter FSM: pick a lane while idle, hold it until its tlast beat is taken.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= AW'(NUM - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_hit) begin
            grant_q <= scan_lane;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (xfer_c && cur_tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXIS_ROUTE_MERGE_OUT_REG_EN
  localparam int unsigned BW = DSIZE + KSIZE + USIZE + 1;

  logic [BW-1:0] buf_q [2];
  logic [1:0]    cnt_q;
  logic [BW-1:0] cur_beat;
  logic          pop_c;

  assign cur_beat = {cur_tdata, cur_tkeep, cur_tuser, cur_tlast};
  assign take_c   = (cnt_q != 2'd2);
  assign pop_c    = (cnt_q != 2'd0) && bus.m_tready;

  assign bus.m_tvalid = (cnt_q != 2'd0);
  assign {bus.m_tdata, bus.m_tkeep, bus.m_tuser, bus.m_tlast} = buf_q[0];

  // Two-entry skid FIFO; head entry drives m_* directly.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= 2'd0;
    end else begin
      case ({xfer_c, pop_c})
        2'b10: begin
          buf_q[cnt_q[0]] <= cur_beat;
          cnt_q           <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          cnt_q    <= cnt_q - 2'd1;
        end
        2'b11: begin
          buf_q[0] <= cur_beat;
        end
        default: ;
      endcase
    end
  end
`else
  assign take_c       = bus.m_tready;
  assign bus.m_tvalid = cur_tvalid;
  assign bus.m_tdata  = cur_tdata;
  assign bus.m_tkeep  = cur_tkeep;
  assign bus.m_tuser  = cur_tuser;
  assign bus.m_tlast  = cur_tlast;
`endif

endmodule

// File: tb/tb_axis_route_merge.sv
// Directed bench for axis_route_merge: vector table for the split half, hand-written
// sequences with a small per-lane source model for the merge half.
module tb_axis_route_merge;
  localparam int unsigned NUM   = 3;
  localparam int unsigned DSIZE = 32;
  localparam int unsigned USIZE = 1;
  localparam int unsigned KSIZE = DSIZE / 8;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axis_route_merge_if #(.NUM(NUM), .DSIZE(DSIZE), .USIZE(USIZE)) bus ();

  axis_route_merge #(.NUM(NUM), .DSIZE(DSIZE), .USIZE(USIZE)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Split vector: inputs for one cycle and the expected lane valids / s_tready.
  typedef struct {
    logic [1:0]  addr;
    logic        vld;
    logic [31:0] data;
    logic        last;
    logic [2:0]  rdy;
    logic [2:0]  exp_dv;
    logic        exp_rdy;
  } vec_t;

  vec_t vt [16];

  // Merge lane source model.
  int unsigned lane_len  [NUM];
  int unsigned lane_pos  [NUM];
  logic [31:0] lane_base [NUM];
  logic        lane_hold [NUM];
  logic [31:0] out_q [$];
  logic [31:0] vpat;
  logic        smp_mvalid;
  logic [2:0]  smp_mmready;

  task automatic drive_lanes();
    for (int i = 0; i < NUM; i++) begin
      bus.mm_tvalid[i]                = (lane_pos[i] < lane_len[i]) && !lane_hold[i];
      bus.mm_tdata[i*DSIZE +: DSIZE]  = lane_base[i] + lane_pos[i];
      bus.mm_tlast[i]                 = (lane_pos[i] + 1 == lane_len[i]);
      bus.mm_tkeep[i*KSIZE +: KSIZE]  = '1;
      bus.mm_tuser[i*USIZE +: USIZE]  = '0;
    end
  endtask

  // One clock: sample at negedge, advance the lane model after the posedge.
  task automatic step();
    logic acc [NUM];
    @(negedge aclk);
    for (int i = 0; i < NUM; i++) acc[i] = bus.mm_tvalid[i] && bus.mm_tready[i];
    if (bus.m_tvalid && bus.m_tready) out_q.push_back(bus.m_tdata);
    smp_mvalid  = bus.m_tvalid;
    smp_mmready = bus.mm_tready;
    vpat        = {vpat[30:0], bus.m_tvalid};
    @(posedge aclk);
    #1;
    for (int i = 0; i < NUM; i++) if (acc[i]) lane_pos[i]++;
    drive_lanes();
  endtask

  task automatic check_out(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] act;
    act = (idx < out_q.size()) ? out_q[idx] : 32'hDEAD_DEAD;
    check(name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{2'd2, 1'b1, 32'hA0, 1'b0, 3'b111, 3'b100, 1'b1};
    vt[1]  = '{2'd2, 1'b1, 32'hA1, 1'b0, 3'b111, 3'b100, 1'b1};
    vt[2]  = '{2'd0, 1'b1, 32'hA2, 1'b0, 3'b111, 3'b100, 1'b1};
    vt[3]  = '{2'd0, 1'b1, 32'hA3, 1'b1, 3'b111, 3'b100, 1'b1};
    vt[4]  = '{2'd1, 1'b1, 32'hB0, 1'b0, 3'b111, 3'b010, 1'b1};
    vt[5]  = '{2'd1, 1'b1, 32'hB1, 1'b0, 3'b101, 3'b010, 1'b0};
    vt[6]  = '{2'd1, 1'b1, 32'hB1, 1'b0, 3'b101, 3'b010, 1'b0};
    vt[7]  = '{2'd1, 1'b1, 32'hB1, 1'b0, 3'b101, 3'b010, 1'b0};
    vt[8]  = '{2'd1, 1'b1, 32'hB1, 1'b0, 3'b111, 3'b010, 1'b1};
    vt[9]  = '{2'd1, 1'b1, 32'hB2, 1'b0, 3'b111, 3'b010, 1'b1};
    vt[10] = '{2'd1, 1'b1, 32'hB3, 1'b1, 3'b111, 3'b010, 1'b1};
    vt[11] = '{2'd3, 1'b1, 32'hC0, 1'b0, 3'b000, 3'b000, 1'b1};
    vt[12] = '{2'd0, 1'b1, 32'hC1, 1'b1, 3'b000, 3'b000, 1'b1};
    vt[13] = '{2'd0, 1'b1, 32'hD0, 1'b1, 3'b001, 3'b001, 1'b1};
    vt[14] = '{2'd0, 1'b0, 32'h00, 1'b0, 3'b000, 3'b000, 1'b0};
    vt[15] = '{2'd1, 1'b1, 32'hE0, 1'b1, 3'b010, 3'b010, 1'b1};

    // Reset state
    areset        = 1'b1;
    bus.addr      = 2'd1;
    bus.s_tdata   = '0;
    bus.s_tkeep   = '1;
    bus.s_tuser   = '0;
    bus.s_tvalid  = 1'b0;
    bus.s_tlast   = 1'b0;
    bus.dm_tready = 3'b010;
    bus.m_tready  = 1'b0;
    vpat          = '0;
    for (int i = 0; i < NUM; i++) begin
      lane_len[i] = 0; lane_pos[i] = 0; lane_base[i] = '0; lane_hold[i] = 1'b0;
    end
    drive_lanes();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready_lane0", 64'(bus.s_tready), 64'd0);
    check("rst_dm_tvalid", 64'(bus.dm_tvalid), 64'd0);
    check("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    check("rst_mm_tready", 64'(bus.mm_tready), 64'd0);
    bus.dm_tready = 3'b001;
    #1;
    check("rst_s_tready_follows_lane0", 64'(bus.s_tready), 64'd1);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Split vector table
    for (int v = 0; v < 16; v++) begin
      bus.addr      = vt[v].addr;
      bus.s_tvalid  = vt[v].vld;
      bus.s_tdata   = vt[v].data;
      bus.s_tlast   = vt[v].last;
      bus.dm_tready = vt[v].rdy;
      @(negedge aclk);
      check($sformatf("split_dm_tvalid[%0d]", v), 64'(bus.dm_tvalid), 64'(vt[v].exp_dv));
      check($sformatf("split_s_tready[%0d]", v), 64'(bus.s_tready), 64'(vt[v].exp_rdy));
      for (int j = 0; j < NUM; j++) begin
        if (vt[v].exp_dv[j]) begin
          check($sformatf("split_data[%0d]", v), 64'(bus.dm_tdata[j*DSIZE +: DSIZE]), 64'(vt[v].data));
          check($sformatf("split_last[%0d]", v), 64'(bus.dm_tlast[j]), 64'(vt[v].last));
        end
      end
      @(posedge aclk);
      #1;
    end
    bus.s_tvalid = 1'b0;

    // Merge: three simultaneous 2-beat packets after reset
    bus.m_tready = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      lane_len[i] = 2; lane_pos[i] = 0; lane_base[i] = 32'h100 * (i + 1);
    end
    drive_lanes();
    out_q.delete();
    vpat = '0;
    repeat (12) step();
    check("rr_count", 64'(out_q.size()), 64'd6);
    check_out("rr_beat0", 0, 32'h100);
    check_out("rr_beat1", 1, 32'h101);
    check_out("rr_beat2", 2, 32'h200);
    check_out("rr_beat3", 3, 32'h201);
    check_out("rr_beat4", 4, 32'h300);
    check_out("rr_beat5", 5, 32'h301);
`ifndef AXIS_ROUTE_MERGE_OUT_REG_EN
    check("rr_bubble_pattern", 64'(vpat[11:0]), 64'(12'b011011011000));
`endif

    // Merge hold: lane 1 stalls mid-packet while lane 0 waits
    lane_len[1] = 3; lane_pos[1] = 0; lane_base[1] = 32'h1100;
    drive_lanes();
    out_q.delete();
    step();
    step();
    lane_hold[1] = 1'b1;
    lane_len[0]  = 2; lane_pos[0] = 0; lane_base[0] = 32'h1000;
    drive_lanes();
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hold_mm_tready[%0d]", c), 64'(smp_mmready), 64'(3'b010));
`ifndef AXIS_ROUTE_MERGE_OUT_REG_EN
      check($sformatf("hold_m_tvalid[%0d]", c), 64'(smp_mvalid), 64'd0);
`endif
    end
    lane_hold[1] = 1'b0;
    drive_lanes();
    repeat (10) step();
    check("hold_count", 64'(out_q.size()), 64'd5);
    check_out("hold_beat0", 0, 32'h1100);
    check_out("hold_beat1", 1, 32'h1101);
    check_out("hold_beat2", 2, 32'h1102);
    check_out("hold_beat3", 3, 32'h1000);
    check_out("hold_beat4", 4, 32'h1001);

    // Reset in the middle of a merge packet
    lane_len[2] = 4; lane_pos[2] = 0; lane_base[2] = 32'h2200;
    drive_lanes();
    step();
    step();
    lane_hold[2] = 1'b1;
    bus.m_tready = 1'b0;
    areset       = 1'b1;
    drive_lanes();
    step();
    areset       = 1'b0;
    lane_hold[2] = 1'b0;
    bus.m_tready = 1'b1;
    lane_len[0] = 1; lane_pos[0] = 0; lane_base[0] = 32'h2000;
    lane_len[1] = 1; lane_pos[1] = 0; lane_base[1] = 32'h2100;
    drive_lanes();
    out_q.delete();
    step();
    check("post_rst_m_tvalid", 64'(smp_mvalid), 64'd0);
    check("post_rst_mm_tready", 64'(smp_mmready), 64'd0);
    repeat (12) step();
    check("post_rst_count", 64'(out_q.size()), 64'd5);
    check_out("post_rst_first_lane0", 0, 32'h2000);
    check_out("post_rst_second_lane1", 1, 32'h2100);
    check_out("post_rst_third_lane2", 2, 32'h2201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
